// File: rtl/ls_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states and
// the misalignment predicate used when LS_MISALIGN_TRAP_EN is defined.
package ls_pkg;

    typedef enum logic [1:0] {
        LS_WORD  = 2'b00,
        LS_HALF  = 2'b01,
        LS_BYTE  = 2'b10,
        LS_BYTEU = 2'b11
    } ls_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR
    } ls_state_e;

    function automatic logic ls_misaligned(input ls_size_e size, input logic [1:0] lo);
        return ((size == LS_WORD) && (lo != 2'b00)) || ((size == LS_HALF) && lo[0]);
    endfunction

endpackage

// File: rtl/ls_mem_unit_if.sv
// Pipeline-side request/response interface and word-memory bus interface.
// master drives the request (pipeline) or the bus (unit); slave is the other end.
interface ls_cpu_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              memwrite;
    logic              memtoreg;
    logic [1:0]        ls_ctrl;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              resp_valid;
    logic [31:0]       rdata;
    logic              misalign;

    modport master (output req_valid, memwrite, memtoreg, ls_ctrl, addr, wdata,
                    input  req_ready, resp_valid, rdata, misalign);
    modport slave  (input  req_valid, memwrite, memtoreg, ls_ctrl, addr, wdata,
                    output req_ready, resp_valid, rdata, misalign);
endinterface

interface ls_bus_if #(parameter int ADDR_W = 32);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/ls_align.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges right-aligned store data into the byte lanes of a read word.
module ls_align
    import ls_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  ls_size_e    size,
    input  logic [31:0] rd_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] st_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = rd_word[{addr_lo, 3'b000} +: 8];
        w_half  = rd_word[{addr_lo[1], 4'b0000} +: 16];
        ld_data = rd_word;
        case (size)
            LS_HALF:  ld_data = {{16{w_half[15]}}, w_half};
            LS_BYTE:  ld_data = {{24{w_byte[7]}}, w_byte};
            LS_BYTEU: ld_data = {24'd0, w_byte};
            default:  ld_data = rd_word;
        endcase
    end

    // Each lane either takes its slice of the store data or keeps the read byte.
    for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic       w_lane_we;
        logic [7:0] w_lane_src;

        assign w_lane_we  = (size == LS_WORD) ? 1'b1 :
                            (size == LS_HALF) ? (addr_lo[1] == LANE[1]) :
                                                (addr_lo == LANE);
        assign w_lane_src = (size == LS_WORD) ? st_data[8*gi +: 8] :
                            (size == LS_HALF) ? st_data[8*(gi%2) +: 8] :
                                                st_data[7:0];
        assign st_merged[8*gi +: 8] = w_lane_we ? w_lane_src : rd_word[8*gi +: 8];
    end

endmodule

// File: rtl/ls_mem_unit.sv
// Load/store unit bridging a pipeline request to a variable-latency word memory.
// Sub-word stores use read-modify-write. Define LS_MISALIGN_TRAP_EN to trap misaligned accesses.
module ls_mem_unit
    import ls_pkg::*;
#(
    parameter int ADDR_W = 32
)(
    input  logic     clk,
    input  logic     reset_n,
    ls_cpu_if.slave  cpu,
    ls_bus_if.master bus
);

    ls_state_e         r_state, w_state_next;
    logic [ADDR_W-1:0] r_addr;
    ls_size_e          r_ctrl;
    logic [31:0]       r_wdata;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_rdata;
    logic              r_resp_valid;
    logic              r_misalign;

    logic              w_accept;
    logic              w_trap;
    logic [31:0]       w_ld_data;
    logic [31:0]       w_merged;

`ifdef LS_MISALIGN_TRAP_EN
    assign w_trap = ls_misaligned(ls_size_e'(cpu.ls_ctrl), cpu.addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    ls_align u_align (
        .addr_lo   (r_addr[1:0]),
        .size      (r_ctrl),
        .rd_word   (bus.mem_rdata),
        .st_data   (r_wdata),
        .ld_data   (w_ld_data),
        .st_merged (w_merged)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Requests with neither memwrite nor memtoreg are not accepted at all.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu.req_valid && (cpu.memwrite || cpu.memtoreg)) begin
                    w_accept = 1'b1;
                    if (w_trap)
                        w_state_next = ST_IDLE;
                    else if (cpu.memwrite)
                        w_state_next = (ls_size_e'(cpu.ls_ctrl) == LS_WORD) ? ST_WR : ST_RMW_RD;
                    else
                        w_state_next = ST_RD;
                end
            end
            ST_RD:     if (bus.mem_ack) w_state_next = ST_IDLE;
            ST_WR:     if (bus.mem_ack) w_state_next = ST_IDLE;
            ST_RMW_RD: if (bus.mem_ack) w_state_next = ST_RMW_WR;
            ST_RMW_WR: if (bus.mem_ack) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr       <= '0;
            r_ctrl       <= LS_WORD;
            r_wdata      <= '0;
            r_mem_wdata  <= '0;
            r_rdata      <= '0;
            r_resp_valid <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_misalign   <= 1'b0;
            if (w_accept) begin
                r_addr  <= cpu.addr;
                r_ctrl  <= ls_size_e'(cpu.ls_ctrl);
                r_wdata <= cpu.wdata;
                if (w_trap) begin
                    r_resp_valid <= 1'b1;
                    r_misalign   <= 1'b1;
                    r_rdata      <= '0;
                end else if (cpu.memwrite) begin
                    r_mem_wdata  <= cpu.wdata;
                end
            end
            if (bus.mem_ack) begin
                case (r_state)
                    ST_RD: begin
                        r_rdata      <= w_ld_data;
                        r_resp_valid <= 1'b1;
                    end
                    ST_RMW_RD: r_mem_wdata <= w_merged;
                    ST_WR, ST_RMW_WR: begin
                        r_rdata      <= '0;
                        r_resp_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cpu.req_ready  = (r_state == ST_IDLE);
    assign cpu.resp_valid = r_resp_valid;
    assign cpu.rdata      = r_rdata;
    assign cpu.misalign   = r_misalign;

    assign bus.mem_req    = (r_state != ST_IDLE);
    assign bus.mem_we     = (r_state == ST_WR) || (r_state == ST_RMW_WR);
    assign bus.mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_ls_mem_unit.sv
// Directed self-checking bench for ls_mem_unit with a variable-latency memory responder.
module tb_ls_mem_unit;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ls_cpu_if #(.ADDR_W(32)) u_cpu ();
    ls_bus_if #(.ADDR_W(32)) u_bus ();

    ls_mem_unit #(.ADDR_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cpu     (u_cpu),
        .bus     (u_bus)
    );

    int total = 0;
    int bad   = 0;

    // memory responder: acks after ack_wait idle cycles, returns rd_word
    int          ack_wait = 0;
    logic [31:0] rd_word  = 32'h0;
    int          wait_cnt = 0;

    initial begin
        u_bus.mem_ack   = 1'b0;
        u_bus.mem_rdata = 32'h0BAD0BAD;
        forever begin
            @(negedge clk);
            if (u_bus.mem_req === 1'b1) begin
                if (wait_cnt >= ack_wait) begin
                    u_bus.mem_ack   = 1'b1;
                    u_bus.mem_rdata = rd_word;
                    wait_cnt        = 0;
                end else begin
                    u_bus.mem_ack   = 1'b0;
                    u_bus.mem_rdata = 32'h0BAD0BAD;
                    wait_cnt        = wait_cnt + 1;
                end
            end else begin
                u_bus.mem_ack = 1'b0;
                wait_cnt      = 0;
            end
        end
    end

    // bus monitor
    int          n_rd = 0, n_wr = 0, n_req_cyc = 0;
    logic [31:0] last_rd_addr = 0, last_wr_addr = 0, last_wr_data = 0;

    always @(posedge clk) begin
        if (u_bus.mem_req === 1'b1) n_req_cyc <= n_req_cyc + 1;
        if (u_bus.mem_req === 1'b1 && u_bus.mem_ack === 1'b1) begin
            if (u_bus.mem_we) begin
                n_wr         <= n_wr + 1;
                last_wr_addr <= u_bus.mem_addr;
                last_wr_data <= u_bus.mem_wdata;
            end else begin
                n_rd         <= n_rd + 1;
                last_rd_addr <= u_bus.mem_addr;
            end
        end
    end

    task automatic issue(input logic we, input logic ld, input logic [1:0] ctrl,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        u_cpu.req_valid = 1'b1;
        u_cpu.memwrite  = we;
        u_cpu.memtoreg  = ld;
        u_cpu.ls_ctrl   = ctrl;
        u_cpu.addr      = a;
        u_cpu.wdata     = wd;
        @(posedge clk);
        #1;
        u_cpu.req_valid = 1'b0;
        u_cpu.memwrite  = 1'b0;
        u_cpu.memtoreg  = 1'b0;
        u_cpu.ls_ctrl   = 2'b00;
        u_cpu.addr      = 32'hFFFF_FFFF;
        u_cpu.wdata     = 32'hFFFF_FFFF;
    endtask

    // cycles counted from the accept cycle (0) to the resp_valid cycle; -1 on timeout
    task automatic wait_resp(output int lat);
        lat = -1;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            if (u_cpu.resp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        u_cpu.req_valid = 1'b0; u_cpu.memwrite = 1'b0; u_cpu.memtoreg = 1'b0;
        u_cpu.ls_ctrl = 2'b00; u_cpu.addr = 32'h0; u_cpu.wdata = 32'h0;
        repeat (2) @(negedge clk);
        total++; if (u_bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", u_bus.mem_req); end
        total++; if (u_bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", u_bus.mem_we); end
        total++; if (u_bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", u_bus.mem_addr); end
        total++; if (u_bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", u_bus.mem_wdata); end
        total++; if (u_cpu.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", u_cpu.resp_valid); end
        total++; if (u_cpu.misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", u_cpu.misalign); end
        total++; if (u_cpu.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", u_cpu.rdata); end
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (u_cpu.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", u_cpu.req_ready); end
        $display("txn reset done");
    endtask

    task automatic test_loads();
        logic [1:0]  ctrl_t [7] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11};
        logic [31:0] addr_t [7] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100, 32'h100, 32'h101};
        logic [31:0] exp_t  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80AA, 32'hFFFF_BBCC,
                                    32'h80AA_BBCC, 32'hFFFF_FFCC, 32'h0000_00BB};
        int lat, rd0, wr0;
        ack_wait = 0;
        rd_word  = 32'h80AA_BBCC;
        for (int k = 0; k < 7; k++) begin
            rd0 = n_rd; wr0 = n_wr;
            issue(1'b0, 1'b1, ctrl_t[k], addr_t[k], 32'h5555_5555);
            wait_resp(lat);
            $display("txn load ctrl=%b addr=%h rdata=%h lat=%0d", ctrl_t[k], addr_t[k], u_cpu.rdata, lat);
            total++; if (lat !== 2) begin bad++; $display("FAIL load_latency[%0d] got=%0d exp=2", k, lat); end
            total++; if (u_cpu.rdata !== exp_t[k]) begin bad++; $display("FAIL load_rdata[%0d] got=%h exp=%h", k, u_cpu.rdata, exp_t[k]); end
            total++; if (u_cpu.misalign !== 1'b0) begin bad++; $display("FAIL load_misalign[%0d] got=%b exp=0", k, u_cpu.misalign); end
            total++; if ((n_rd - rd0) !== 1 || (n_wr - wr0) !== 0) begin bad++; $display("FAIL load_bus[%0d] got rd=%0d wr=%0d exp rd=1 wr=0", k, n_rd - rd0, n_wr - wr0); end
            total++; if (last_rd_addr !== {addr_t[k][31:2], 2'b00}) begin bad++; $display("FAIL load_addr[%0d] got=%h exp=%h", k, last_rd_addr, {addr_t[k][31:2], 2'b00}); end
        end
        @(negedge clk);
        total++; if (u_cpu.resp_valid !== 1'b0) begin bad++; $display("FAIL resp_pulse_width got=%b exp=0", u_cpu.resp_valid); end
    endtask

    task automatic test_sub_stores();
        logic        we_t   [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic        ld_t   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  ctrl_t [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] addr_t [4] = '{32'h202, 32'h201, 32'h203, 32'h301};
        logic [31:0] wd_t   [4] = '{32'h0000_1234, 32'h0000_00AB, 32'h0000_00AB, 32'h0000_005A};
        logic [31:0] exp_t  [4] = '{32'h1234_BEEF, 32'hDEAD_ABEF, 32'hABAD_BEEF, 32'hDEAD_5AEF};
        int lat, rd0, wr0;
        ack_wait = 0;
        rd_word  = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            rd0 = n_rd; wr0 = n_wr;
            issue(we_t[k], ld_t[k], ctrl_t[k], addr_t[k], wd_t[k]);
            wait_resp(lat);
            $display("txn store ctrl=%b addr=%h wdata=%h mem_wdata=%h lat=%0d", ctrl_t[k], addr_t[k], wd_t[k], last_wr_data, lat);
            total++; if (lat !== 3) begin bad++; $display("FAIL sub_store_latency[%0d] got=%0d exp=3", k, lat); end
            total++; if ((n_rd - rd0) !== 1 || (n_wr - wr0) !== 1) begin bad++; $display("FAIL sub_store_bus[%0d] got rd=%0d wr=%0d exp rd=1 wr=1", k, n_rd - rd0, n_wr - wr0); end
            total++; if (last_wr_data !== exp_t[k]) begin bad++; $display("FAIL sub_store_data[%0d] got=%h exp=%h", k, last_wr_data, exp_t[k]); end
            total++; if (last_wr_addr !== {addr_t[k][31:2], 2'b00}) begin bad++; $display("FAIL sub_store_addr[%0d] got=%h exp=%h", k, last_wr_addr, {addr_t[k][31:2], 2'b00}); end
            total++; if (u_cpu.rdata !== 32'h0) begin bad++; $display("FAIL sub_store_rdata[%0d] got=%h exp=0", k, u_cpu.rdata); end
        end
    endtask

    task automatic test_word_store_wait();
        int cyc, rd0, wr0;
        logic seen_resp;
        ack_wait = 3;
        rd0 = n_rd; wr0 = n_wr;
        cyc = 0; seen_resp = 1'b0;
        issue(1'b1, 1'b0, 2'b00, 32'h40, 32'hCAFE_F00D);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (u_bus.mem_req !== 1'b1) begin
                seen_resp = u_cpu.resp_valid;
                break;
            end
            cyc++;
            total++; if (u_cpu.req_ready !== 1'b0) begin bad++; $display("FAIL sw_req_ready cyc=%0d got=%b exp=0", cyc, u_cpu.req_ready); end
            total++; if (u_bus.mem_addr !== 32'h40 || u_bus.mem_wdata !== 32'hCAFE_F00D || u_bus.mem_we !== 1'b1)
                begin bad++; $display("FAIL sw_bus_stable cyc=%0d got addr=%h data=%h we=%b exp addr=00000040 data=cafef00d we=1", cyc, u_bus.mem_addr, u_bus.mem_wdata, u_bus.mem_we); end
        end
        $display("txn sw addr=00000040 req_cycles=%0d", cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL sw_req_cycles got=%0d exp=4", cyc); end
        total++; if (seen_resp !== 1'b1) begin bad++; $display("FAIL sw_resp got=%b exp=1", seen_resp); end
        total++; if ((n_wr - wr0) !== 1 || (n_rd - rd0) !== 0) begin bad++; $display("FAIL sw_bus got rd=%0d wr=%0d exp rd=0 wr=1", n_rd - rd0, n_wr - wr0); end
        ack_wait = 0;
    endtask

    task automatic test_reset_mid_rmw();
        int wr0, resp_seen;
        logic in_wr;
        ack_wait = 3;
        rd_word  = 32'h0;
        wr0 = n_wr; in_wr = 1'b0; resp_seen = 0;
        issue(1'b1, 1'b0, 2'b10, 32'h500, 32'h77);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (u_bus.mem_we === 1'b1) begin in_wr = 1'b1; break; end
        end
        total++; if (in_wr !== 1'b1) begin bad++; $display("FAIL rst_rmw_reach_wr got=%b exp=1", in_wr); end
        #1 reset_n = 1'b0;
        #1;
        total++; if (u_bus.mem_req !== 1'b0 || u_bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_rmw_mem_req got req=%b we=%b exp 0 0", u_bus.mem_req, u_bus.mem_we); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (u_cpu.resp_valid !== 1'b0) resp_seen++;
        end
        $display("txn reset in RMW_WR, writes=%0d", n_wr - wr0);
        total++; if (resp_seen !== 0) begin bad++; $display("FAIL rst_rmw_resp got=%0d exp=0", resp_seen); end
        total++; if ((n_wr - wr0) !== 0) begin bad++; $display("FAIL rst_rmw_write got=%0d exp=0", n_wr - wr0); end
        total++; if (u_cpu.req_ready !== 1'b1 || u_bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_rmw_idle got ready=%b req=%b exp 1 0", u_cpu.req_ready, u_bus.mem_req); end
        ack_wait = 0;
    endtask

    task automatic test_misalign();
        int lat, rq0;
        ack_wait = 0;
        rd_word  = 32'h1122_3344;
        rq0 = n_req_cyc;
        issue(1'b0, 1'b1, 2'b00, 32'h41, 32'h0);
        wait_resp(lat);
        $display("txn lw addr=00000041 rdata=%h misalign=%b lat=%0d", u_cpu.rdata, u_cpu.misalign, lat);
`ifdef LS_MISALIGN_TRAP_EN
        total++; if (lat !== 1) begin bad++; $display("FAIL mis_latency got=%0d exp=1", lat); end
        total++; if (u_cpu.misalign !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b exp=1", u_cpu.misalign); end
        total++; if (u_cpu.rdata !== 32'h0) begin bad++; $display("FAIL mis_rdata got=%h exp=0", u_cpu.rdata); end
        total++; if ((n_req_cyc - rq0) !== 0) begin bad++; $display("FAIL mis_mem_req got=%0d exp=0", n_req_cyc - rq0); end
`else
        total++; if (lat !== 2) begin bad++; $display("FAIL mis_latency got=%0d exp=2", lat); end
        total++; if (u_cpu.misalign !== 1'b0) begin bad++; $display("FAIL mis_flag got=%b exp=0", u_cpu.misalign); end
        total++; if (u_cpu.rdata !== 32'h1122_3344) begin bad++; $display("FAIL mis_rdata got=%h exp=11223344", u_cpu.rdata); end
        total++; if (last_rd_addr !== 32'h40) begin bad++; $display("FAIL mis_addr got=%h exp=00000040", last_rd_addr); end
`endif
    endtask

    task automatic test_ignore_null();
        int rq0, resp_seen;
        rq0 = n_req_cyc; resp_seen = 0;
        issue(1'b0, 1'b0, 2'b00, 32'h80, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (u_cpu.resp_valid !== 1'b0) resp_seen++;
        end
        $display("txn null request ignored");
        total++; if ((n_req_cyc - rq0) !== 0) begin bad++; $display("FAIL null_mem_req got=%0d exp=0", n_req_cyc - rq0); end
        total++; if (resp_seen !== 0) begin bad++; $display("FAIL null_resp got=%0d exp=0", resp_seen); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] got0;
        ack_wait = 0;
        rd_word  = 32'hA1B2_C3D4;
        issue(1'b0, 1'b1, 2'b11, 32'h602, 32'h0);
        wait_resp(lat);
        got0 = u_cpu.rdata;
        // next request presented during the response cycle
        u_cpu.req_valid = 1'b1; u_cpu.memtoreg = 1'b1; u_cpu.ls_ctrl = 2'b01; u_cpu.addr = 32'h600;
        @(posedge clk); #1;
        u_cpu.req_valid = 1'b0; u_cpu.memtoreg = 1'b0;
        wait_resp(lat);
        $display("txn back_to_back rdata0=%h rdata1=%h lat=%0d", got0, u_cpu.rdata, lat);
        total++; if (got0 !== 32'h0000_00B2) begin bad++; $display("FAIL b2b_first got=%h exp=000000b2", got0); end
        total++; if (u_cpu.rdata !== 32'hFFFF_C3D4) begin bad++; $display("FAIL b2b_second got=%h exp=ffffc3d4", u_cpu.rdata); end
        total++; if (lat !== 2) begin bad++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_sub_stores();
        test_word_store_wait();
        test_reset_mid_rmw();
        test_misalign();
        test_ignore_null();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ls_mem_unit.md
LS_MEM_UNIT -- requirements
Module: ls_mem_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a memory request.
REQ-005 SHALL have port req_ready  output  1  unit accepts the request this cycle.
REQ-006 SHALL have port memwrite  input  1  store request.
REQ-007 SHALL have port memtoreg  input  1  load request.
REQ-008 SHALL have port ls_ctrl  input  2  size: 00 word, 01 half, 10 byte, 11 byte-unsigned.
REQ-009 SHALL have port addr  input  ADDR_W  byte address.
REQ-010 SHALL have port wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata  output  32  extended load result.
REQ-013 SHALL have port misalign  output  1  misaligned-access flag, valid with resp_valid.
REQ-014 SHALL have port mem_req, mem_we  output  1 each  word-memory request and write enable.
REQ-015 SHALL have port mem_addr  output  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}.
REQ-016 SHALL have port mem_wdata  output  32; mem_rdata  input  32; mem_ack  input  1  variable-latency completion.

Function
REQ-017 SHALL implement FSM IDLE, RD, WR, RMW_RD, RMW_WR; req_ready=1 only in IDLE.
REQ-018 SHALL register the request on req_valid&&req_ready; inputs may change after acceptance.
REQ-019 SHALL give memwrite priority when memwrite and memtoreg are both 1; req_valid with both 0 SHALL be ignored (no state change, no response).
REQ-020 SHALL route loads IDLE->RD, word stores IDLE->WR, half/byte stores IDLE->RMW_RD->RMW_WR.
REQ-021 SHALL hold mem_req, mem_we, mem_addr, mem_wdata stable in RD/WR/RMW_RD/RMW_WR until mem_ack; mem_req=0 in IDLE.
REQ-022 SHALL, in RMW_RD on mem_ack, register mem_rdata merged with the store lane(s) and enter RMW_WR with mem_we=1.
REQ-023 SHALL, on the final mem_ack, return to IDLE and pulse resp_valid for exactly one cycle in the next cycle (the first IDLE cycle).
REQ-024 SHALL use little-endian lanes: byte k=addr[1:0] at bits 8k+7:8k; half h=addr[1] at bits 16h+15:16h.
REQ-025 SHALL sign-extend ls_ctrl 01/10 loads, zero-extend 11; rdata=0 for stores.
REQ-026 SHALL treat a store with ls_ctrl 11 as a byte store.
REQ-027 SHALL ignore mem_ack when mem_req=0.
REQ-028 SHALL give load latency accept-to-resp_valid of 2 cycles with zero-wait mem_ack; byte/half store 3 cycles.

Reset
REQ-029 SHALL on reset_n=0 immediately enter IDLE, drive mem_req=0, resp_valid=0, misalign=0, rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 SHALL abandon an in-flight transaction on reset with no response; a partial RMW SHALL NOT issue its write.

Configuration
REQ-031 SHALL, with LS_MISALIGN_TRAP_EN defined, flag word with addr[1:0]!=0 or half with addr[0]=1: no memory access, resp_valid next cycle with misalign=1, rdata=0.
REQ-032 SHALL, without LS_MISALIGN_TRAP_EN, ignore addr[1:0] for words and addr[0] for halves, and tie misalign to 0.

Structure
REQ-033 SHALL place ls_ctrl encodings and the FSM state enum in package ls_pkg.
REQ-034 SHALL place lane extraction/extension and store merge in combinational sub-module ls_align.

Verification
REQ-035 SHALL cover: LB addr 0x103, mem_rdata 0x80AABBCC, ack 0-wait -> resp_valid 2 cycles after accept, rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SHALL cover: SH addr 0x202, wdata 0x1234, read word 0xDEADBEEF -> one read then write mem_wdata 0x1234BEEF at mem_addr 0x200.
REQ-037 SHALL cover: SW addr 0x40 with mem_ack delayed 3 cycles -> mem_req held 4 cycles, single write, req_ready 0 throughout.
REQ-038 SHALL cover: reset_n low in RMW_WR before ack -> mem_req 0 same cycle, no resp_valid, IDLE after release.
REQ-039 SHALL cover: LW addr 0x41 -> with LS_MISALIGN_TRAP_EN misalign=1, no mem_req; without, read of 0x40.
REQ-040 SHALL cover: memwrite=memtoreg=1, ls_ctrl 10 -> byte store performed, no load.
